// File: rtl/spi_pkg.sv
// Shared types and sizing for the SPI responder shift engine.
package spi_pkg;

  localparam int WORD_BITS_DEF   = 24;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Bit counter width, wide enough to hold WORD_BITS itself
  function automatic int cnt_w(input int word_bits);
    return $clog2(word_bits + 1);
  endfunction

  localparam int CNT_W_DEF = $clog2(WORD_BITS_DEF + 1);

endpackage

// File: rtl/spi_input_sync.sv
// Multi-lane synchroniser; the low EDGE_LANES lanes also get rise/fall detect,
// the remaining lanes only expose their synchronised level.
module spi_input_sync #(
  parameter int                   NUM_LANES  = 3,
  parameter int                   EDGE_LANES = 2,
  parameter int                   STAGES     = 2,
  parameter logic [NUM_LANES-1:0] IDLE_LVL   = '0
) (
  input  logic                            system_clock,
  input  logic                            reset,
  input  logic [NUM_LANES-1:0]            async_in,
  output logic [NUM_LANES-EDGE_LANES-1:0] lvl,
  output logic [EDGE_LANES-1:0]           rise,
  output logic [EDGE_LANES-1:0]           fall
);

  logic [NUM_LANES-1:0][STAGES-1:0] chain;
  logic [EDGE_LANES-1:0]            dly;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) chain[i] <= {STAGES{IDLE_LVL[i]}};
      for (int j = 0; j < EDGE_LANES; j++) dly[j] <= IDLE_LVL[j];
    end else begin
      for (int i = 0; i < NUM_LANES; i++) chain[i] <= {chain[i][STAGES-2:0], async_in[i]};
      for (int j = 0; j < EDGE_LANES; j++) dly[j] <= chain[j][STAGES-1];
    end
  end

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      if (g < EDGE_LANES) begin : g_edge
        assign rise[g] =  chain[g][STAGES-1] & ~dly[g];
        assign fall[g] = ~chain[g][STAGES-1] &  dly[g];
      end else begin : g_lvl
        assign lvl[g-EDGE_LANES] = chain[g][STAGES-1];
      end
    end
  endgenerate

endmodule

// File: rtl/spi_responder_shift.sv
// SPI mode-1 target: oversampled CS/SCLK/MOSI, MSB-first word shift in/out,
// single-word transmit holding register.
module spi_responder_shift
  import spi_pkg::*;
#(
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 CS,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  input  logic [WORD_BITS-1:0] tx_word,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 frame_abort,
  output logic                 busy
);

  localparam int             CW   = cnt_w(WORD_BITS);
  localparam logic [CW-1:0]  LAST = CW'(WORD_BITS - 1);

  // Lane 0 = CS (idles high), lane 1 = SCLK, lane 2 = MOSI (level only)
  logic [0:0] sync_lvl;
  logic [1:0] sync_rise, sync_fall;

  spi_input_sync #(
    .NUM_LANES (3),
    .EDGE_LANES(2),
    .STAGES    (SYNC_STAGES),
    .IDLE_LVL  (3'b001)
  ) u_sync (
    .system_clock(system_clock),
    .reset       (reset),
    .async_in    ({SPI_MOSI, SPI_SCLK, CS}),
    .lvl         (sync_lvl),
    .rise        (sync_rise),
    .fall        (sync_fall)
  );

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi;
  assign cs_rise   = sync_rise[0];
  assign cs_fall   = sync_fall[0];
  assign sclk_rise = sync_rise[1];
  assign sclk_fall = sync_fall[1];
  assign mosi      = sync_lvl[0];

  spi_state_e           state, state_nx;
  logic [CW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] shift_tx, shift_rx, hold_word, tx_src;
  logic                 hold_full;
  logic                 act_rise, act_fall, word_start, xfer, load_ok;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs_fall) state_nx = ACTIVE;
      ACTIVE:  if (cs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // CS edges take priority over any SCLK edge seen in the same cycle
  assign act_rise   = (state == ACTIVE) & sclk_rise & ~cs_rise & ~cs_fall;
  assign act_fall   = (state == ACTIVE) & sclk_fall & ~cs_rise & ~cs_fall;
  assign word_start = act_rise & (bit_cnt == '0);
  assign xfer       = word_start & hold_full;
  assign tx_ready   = ~hold_full | xfer;
  assign load_ok    = tx_load & tx_ready;
  assign busy       = (state == ACTIVE);

  always_comb begin
    tx_src = shift_tx;
    if (word_start) tx_src = hold_full ? hold_word : '0;
  end

  // A load on the transfer cycle refills the register after the old word leaves
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      hold_word <= '0;
      hold_full <= 1'b0;
    end else if (load_ok) begin
      hold_word <= tx_word;
      hold_full <= 1'b1;
    end else if (xfer) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      SPI_MISO    <= 1'b0;
      bit_cnt     <= '0;
      shift_tx    <= '0;
      shift_rx    <= '0;
      rx_word     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall) bit_cnt <= '0;
      end else if (cs_rise) begin
        SPI_MISO    <= 1'b0;
        bit_cnt     <= '0;
        shift_rx    <= '0;
        frame_abort <= (bit_cnt != '0);
      end else begin
        if (act_rise) begin
          SPI_MISO <= tx_src[WORD_BITS-1];
          shift_tx <= tx_src << 1;
          if (word_start && !hold_full) tx_underrun <= 1'b1;
        end
        if (act_fall) begin
          shift_rx <= {shift_rx[WORD_BITS-2:0], mosi};
          if (bit_cnt == LAST) begin
            rx_word  <= {shift_rx[WORD_BITS-2:0], mosi};
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
